// File: rtl/rm_ctrl_pipeline_if.sv
// Handshake and status bundle between the lane allocator/monitor and rm_ctrl_pipeline.
// The master drives offers, stalls and kills; the slave (the pipeline) reports stage contents and lane occupancy.
interface rm_ctrl_pipeline_if #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = $clog2(NUM_LANES),
    parameter int TAG_W      = 16,
    parameter int CNT_W      = $clog2(NUM_STAGES + 1)
);
    logic                           ctrl_valid_i;
    logic [LANE_W-1:0]              ctrl_lane_i;
    logic [TAG_W-1:0]               ctrl_tag_i;
    logic                           ctrl_ready_o;
    logic [NUM_STAGES-1:0]          stall_i;
    logic                           flush_i;
    logic [NUM_LANES-1:0]           lane_kill_i;
    logic [NUM_STAGES-1:0]          stage_valid_o;
    logic [NUM_STAGES*LANE_W-1:0]   stage_lane_o;
    logic [NUM_STAGES*TAG_W-1:0]    stage_tag_o;
    logic [NUM_LANES-1:0]           lane_retire_o;
    logic [NUM_LANES-1:0]           lane_busy_o;
    logic [NUM_LANES*CNT_W-1:0]     lane_cnt_o;
    logic                           err_o;

    modport master (
        output ctrl_valid_i, ctrl_lane_i, ctrl_tag_i, stall_i, flush_i, lane_kill_i,
        input  ctrl_ready_o, stage_valid_o, stage_lane_o, stage_tag_o,
               lane_retire_o, lane_busy_o, lane_cnt_o, err_o
    );

    modport slave (
        input  ctrl_valid_i, ctrl_lane_i, ctrl_tag_i, stall_i, flush_i, lane_kill_i,
        output ctrl_ready_o, stage_valid_o, stage_lane_o, stage_tag_o,
               lane_retire_o, lane_busy_o, lane_cnt_o, err_o
    );
endinterface

// File: rtl/rm_ctrl_pipeline.sv
// Runtime-monitor control pipeline: carries {lane, tag} through NUM_STAGES detector stages
// with per-stage stall and bubble collapse, flush, per-lane kill, and per-lane occupancy tracking.
module rm_ctrl_pipeline #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_LANES  = 4,
    parameter int LANE_W     = $clog2(NUM_LANES),
    parameter int TAG_W      = 16,
    parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rm_ctrl_pipeline_if.slave bus
);

    localparam logic [LANE_W:0] LANE_LIM = (LANE_W + 1)'(NUM_LANES);

    // Looks up a per-lane flag without indexing past NUM_LANES for out-of-range lane codes.
    function automatic logic lane_bit(input logic [NUM_LANES-1:0] vec, input logic [LANE_W-1:0] lane);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            hit = hit | (vec[l] & (lane == LANE_W'(l)));
        end
        return hit;
    endfunction

    logic [NUM_STAGES-1:0]  valid_r;
    logic [LANE_W-1:0]      lane_r    [NUM_STAGES];
    logic [TAG_W-1:0]       tag_r     [NUM_STAGES];
    logic [CNT_W-1:0]       cnt_r     [NUM_LANES];
    logic [NUM_LANES-1:0]   busy_r;
    logic                   err_r;

    logic [NUM_STAGES-1:0]  adv_s;
    logic [NUM_STAGES:0]    acc_s;
    logic                   lane_ok_s;
    logic                   accept_s;
    logic [NUM_LANES-1:0]   retire_s;
    logic [NUM_STAGES-1:0]  in_v_s;
    logic [LANE_W-1:0]      in_lane_s [NUM_STAGES];
    logic [TAG_W-1:0]       in_tag_s  [NUM_STAGES];
    logic [CNT_W-1:0]       cnt_nxt_s [NUM_LANES];

    // Flow control, resolved from the last stage backwards; acc_s[NUM_STAGES] models the always-open exit.
    always_comb begin
        adv_s              = '0;
        acc_s              = '0;
        acc_s[NUM_STAGES]  = 1'b1;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            adv_s[k] = valid_r[k] & ~bus.stall_i[k] & acc_s[k+1];
            acc_s[k] = ~valid_r[k] | adv_s[k];
        end
        lane_ok_s = ({1'b0, bus.ctrl_lane_i} < LANE_LIM);
        accept_s  = bus.ctrl_valid_i & acc_s[0] & ~bus.flush_i & lane_ok_s
                  & ~lane_bit(bus.lane_kill_i, bus.ctrl_lane_i);
        for (int l = 0; l < NUM_LANES; l++) begin
            retire_s[l] = adv_s[NUM_STAGES-1] & (lane_r[NUM_STAGES-1] == LANE_W'(l))
                        & ~bus.flush_i & ~bus.lane_kill_i[l];
        end
    end

    // Data arriving at each stage: the accepted offer for stage 0, the advancing neighbour otherwise.
    always_comb begin
        in_v_s       = '0;
        in_v_s[0]    = accept_s;
        in_lane_s[0] = bus.ctrl_lane_i;
        in_tag_s[0]  = bus.ctrl_tag_i;
        for (int k = 1; k < NUM_STAGES; k++) begin
            in_v_s[k]    = adv_s[k-1];
            in_lane_s[k] = lane_r[k-1];
            in_tag_s[k]  = tag_r[k-1];
        end
    end

    // Next in-flight count per lane; kill and flush override accept/retire accounting.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            cnt_nxt_s[l] = (bus.flush_i | bus.lane_kill_i[l]) ? '0 :
                           cnt_r[l] + CNT_W'(accept_s & (bus.ctrl_lane_i == LANE_W'(l)))
                                    - CNT_W'(retire_s[l]);
        end
    end

    // Stage registers: a killed entry is cleared whether it moves or holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                lane_r[k] <= '0;
                tag_r[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (bus.flush_i) begin
                    valid_r[k] <= 1'b0;
                end else if (in_v_s[k]) begin
                    valid_r[k] <= ~lane_bit(bus.lane_kill_i, in_lane_s[k]);
                    lane_r[k]  <= in_lane_s[k];
                    tag_r[k]   <= in_tag_s[k];
                end else if (adv_s[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k] & ~lane_bit(bus.lane_kill_i, lane_r[k]);
                end
            end
        end
    end

    // Lane occupancy counters, busy flags and the sticky invalid-lane error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= '0;
            err_r  <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                cnt_r[l] <= '0;
            end
        end else begin
            err_r <= err_r | (bus.ctrl_valid_i & ~lane_ok_s);
            for (int l = 0; l < NUM_LANES; l++) begin
                cnt_r[l]  <= cnt_nxt_s[l];
                busy_r[l] <= (cnt_nxt_s[l] != '0);
            end
        end
    end

    assign bus.ctrl_ready_o  = acc_s[0];
    assign bus.lane_retire_o = retire_s;
    assign bus.stage_valid_o = valid_r;
    assign bus.lane_busy_o   = busy_r;
    assign bus.err_o         = err_r;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage_out
        assign bus.stage_lane_o[k*LANE_W +: LANE_W] = lane_r[k];
        assign bus.stage_tag_o[k*TAG_W +: TAG_W]    = tag_r[k];
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_out
        assign bus.lane_cnt_o[l*CNT_W +: CNT_W] = cnt_r[l];
    end

endmodule

// File: tb/tb_rm_ctrl_pipeline.sv
// Directed bench for rm_ctrl_pipeline: a scoreboard queue of accepted {lane, tag} entries is
// popped on every retire pulse; stage, counter and flag values are checked at fixed points.
module tb_rm_ctrl_pipeline;
    localparam int NS = 4;
    localparam int NL = 4;
    localparam int LW = 3;   // one spare bit so lane codes >= NUM_LANES can be offered
    localparam int TW = 16;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rm_ctrl_pipeline_if #(.NUM_STAGES(NS), .NUM_LANES(NL), .LANE_W(LW), .TAG_W(TW), .CNT_W(CW)) bus ();

    rm_ctrl_pipeline #(.NUM_STAGES(NS), .NUM_LANES(NL), .LANE_W(LW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [LW-1:0] lane;
        logic [TW-1:0] tag;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int l);
        return bus.lane_cnt_o[l*CW +: CW];
    endfunction

    task automatic push(input logic [LW-1:0] lane, input logic [TW-1:0] tag);
        ent_t e;
        e.lane = lane;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic sb_kill(input logic [LW-1:0] lane);
        ent_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].lane != lane) keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic offer(input logic v, input logic [LW-1:0] lane, input logic [TW-1:0] tag);
        bus.ctrl_valid_i = v;
        bus.ctrl_lane_i  = lane;
        bus.ctrl_tag_i   = tag;
    endtask

    // Settle, score any retire pulse against the queue head, then advance one clock.
    task automatic tick();
        ent_t e;
        #1;
        if (bus.lane_retire_o != '0) begin
            if (sb.size() == 0) begin
                chk("retire_unexpected", 32'(bus.lane_retire_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("retire_lane", 32'(bus.lane_retire_o), 32'(4'b0001 << e.lane));
                chk("retire_tag", 32'(bus.stage_tag_o[(NS-1)*TW +: TW]), 32'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        offer(1'b0, 3'd0, 16'h0);
        bus.stall_i     = 4'b0000;
        bus.flush_i     = 1'b0;
        bus.lane_kill_i = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.stage_valid_o), 32'd0);
        chk("rst_ready", 32'(bus.ctrl_ready_o), 32'd1);
        chk("rst_retire", 32'(bus.lane_retire_o), 32'd0);
        chk("rst_cnt", 32'(bus.lane_cnt_o), 32'd0);
        chk("rst_busy", 32'(bus.lane_busy_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_lanes", 32'(bus.stage_lane_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single entry: latency and counter
        offer(1'b1, 3'd2, 16'h1234);
        #1 chk("t1_ready", 32'(bus.ctrl_ready_o), 32'd1);
        push(3'd2, 16'h1234);
        tick();
        offer(1'b0, 3'd0, 16'h0);
        chk("t1_valid_s0", 32'(bus.stage_valid_o), 32'b0001);
        chk("t1_lane_s0", 32'(bus.stage_lane_o[0 +: LW]), 32'd2);
        chk("t1_tag_s0", 32'(bus.stage_tag_o[0 +: TW]), 32'h1234);
        chk("t1_cnt2_up", 32'(cnt(2)), 32'd1);
        chk("t1_busy", 32'(bus.lane_busy_o), 32'b0100);
        tick();
        chk("t1_valid_s1", 32'(bus.stage_valid_o), 32'b0010);
        tick();
        tick();
        chk("t1_valid_s3", 32'(bus.stage_valid_o), 32'b1000);
        #1 chk("t1_retire", 32'(bus.lane_retire_o), 32'b0100);
        tick();
        chk("t1_valid_end", 32'(bus.stage_valid_o), 32'd0);
        chk("t1_cnt2_down", 32'(cnt(2)), 32'd0);
        chk("t1_busy_end", 32'(bus.lane_busy_o), 32'd0);

        // Bubble collapse under a 3-cycle stall of the last stage
        offer(1'b1, 3'd0, 16'hA000); push(3'd0, 16'hA000); tick();
        offer(1'b0, 3'd0, 16'h0); tick();
        offer(1'b1, 3'd1, 16'hA001); push(3'd1, 16'hA001); tick();
        offer(1'b1, 3'd2, 16'hA002); push(3'd2, 16'hA002); tick();
        bus.stall_i = 4'b1000;
        offer(1'b1, 3'd3, 16'hA003);
        #1 chk("t2_ready_bubble", 32'(bus.ctrl_ready_o), 32'd1);
        push(3'd3, 16'hA003);
        tick();
        chk("t2_full", 32'(bus.stage_valid_o), 32'b1111);
        chk("t2_lanes", 32'(bus.stage_lane_o), 32'({3'd0, 3'd1, 3'd2, 3'd3}));
        offer(1'b1, 3'd0, 16'hB0B0);
        #1 chk("t2_ready_full1", 32'(bus.ctrl_ready_o), 32'd0);
        tick();
        #1 chk("t2_ready_full2", 32'(bus.ctrl_ready_o), 32'd0);
        chk("t2_cnt0", 32'(cnt(0)), 32'd1);
        tick();
        bus.stall_i = 4'b0000;
        #1 chk("t2_ready_release", 32'(bus.ctrl_ready_o), 32'd1);
        push(3'd0, 16'hB0B0);
        tick();
        offer(1'b0, 3'd0, 16'h0);
        repeat (4) tick();
        chk("t2_sb_drained", 32'(sb.size()), 32'd0);
        chk("t2_valid_end", 32'(bus.stage_valid_o), 32'd0);

        // Accept and retire on lane 1 in the same cycle
        offer(1'b1, 3'd1, 16'hC001); push(3'd1, 16'hC001); tick();
        offer(1'b0, 3'd0, 16'h0);
        repeat (3) tick();
        offer(1'b1, 3'd1, 16'hC002);
        #1 chk("t3_retire", 32'(bus.lane_retire_o), 32'b0010);
        chk("t3_cnt1_before", 32'(cnt(1)), 32'd1);
        push(3'd1, 16'hC002);
        tick();
        offer(1'b0, 3'd0, 16'h0);
        chk("t3_cnt1_same", 32'(cnt(1)), 32'd1);
        chk("t3_busy1", 32'(bus.lane_busy_o[1]), 32'd1);
        repeat (4) tick();
        chk("t3_cnt1_end", 32'(cnt(1)), 32'd0);
        chk("t3_sb_drained", 32'(sb.size()), 32'd0);

        // Lane kill on a full pipeline holding lanes {0,1,0,1}
        bus.stall_i = 4'b1000;
        offer(1'b1, 3'd1, 16'hD001); push(3'd1, 16'hD001); tick();
        offer(1'b1, 3'd0, 16'hD002); push(3'd0, 16'hD002); tick();
        offer(1'b1, 3'd1, 16'hD003); push(3'd1, 16'hD003); tick();
        offer(1'b1, 3'd0, 16'hD004); push(3'd0, 16'hD004); tick();
        offer(1'b0, 3'd0, 16'h0);
        chk("t4_full", 32'(bus.stage_valid_o), 32'b1111);
        chk("t4_cnt0_full", 32'(cnt(0)), 32'd2);
        bus.lane_kill_i = 4'b0001;
        #1 chk("t4_retire_kill", 32'(bus.lane_retire_o), 32'd0);
        sb_kill(3'd0);
        tick();
        bus.lane_kill_i = 4'b0000;
        chk("t4_valid_after", 32'(bus.stage_valid_o), 32'b1010);
        chk("t4_cnt0", 32'(cnt(0)), 32'd0);
        chk("t4_cnt1", 32'(cnt(1)), 32'd2);
        chk("t4_busy", 32'(bus.lane_busy_o), 32'b0010);
        bus.stall_i = 4'b0000;
        repeat (4) tick();
        chk("t4_sb_drained", 32'(sb.size()), 32'd0);
        chk("t4_cnt1_end", 32'(cnt(1)), 32'd0);

        // Flush while full and while offering
        bus.stall_i = 4'b1000;
        for (int i = 0; i < NS; i++) begin
            offer(1'b1, 3'(i), 16'hE000 + 16'(i));
            push(3'(i), 16'hE000 + 16'(i));
            tick();
        end
        offer(1'b1, 3'd2, 16'hEEEE);
        bus.stall_i = 4'b0000;
        bus.flush_i = 1'b1;
        #1 chk("t5_retire_flush", 32'(bus.lane_retire_o), 32'd0);
        sb.delete();
        tick();
        bus.flush_i = 1'b0;
        offer(1'b0, 3'd0, 16'h0);
        chk("t5_valid", 32'(bus.stage_valid_o), 32'd0);
        chk("t5_cnt", 32'(bus.lane_cnt_o), 32'd0);
        chk("t5_busy", 32'(bus.lane_busy_o), 32'd0);
        tick();
        chk("t5_not_accepted", 32'(bus.stage_valid_o), 32'd0);

        // Invalid lane, then asynchronous reset during a stall
        offer(1'b1, 3'd5, 16'h5555);
        tick();
        offer(1'b0, 3'd0, 16'h0);
        chk("t6_drop_valid", 32'(bus.stage_valid_o), 32'd0);
        chk("t6_err", 32'(bus.err_o), 32'd1);
        chk("t6_cnt", 32'(bus.lane_cnt_o), 32'd0);
        tick();
        chk("t6_err_sticky", 32'(bus.err_o), 32'd1);
        bus.stall_i = 4'b0001;
        offer(1'b1, 3'd3, 16'h3333);
        tick();
        offer(1'b0, 3'd0, 16'h0);
        chk("t6_held", 32'(bus.stage_valid_o), 32'b0001);
        tick();
        chk("t6_held2", 32'(bus.stage_valid_o), 32'b0001);
        chk("t6_cnt3", 32'(cnt(3)), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.stage_valid_o), 32'd0);
        chk("t6_rst_err", 32'(bus.err_o), 32'd0);
        chk("t6_rst_cnt", 32'(bus.lane_cnt_o), 32'd0);
        chk("t6_rst_busy", 32'(bus.lane_busy_o), 32'd0);
        chk("t6_rst_ready", 32'(bus.ctrl_ready_o), 32'd1);
        chk("t6_rst_retire", 32'(bus.lane_retire_o), 32'd0);
        sb.delete();
        bus.stall_i = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_post_valid", 32'(bus.stage_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
